mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (read/write with byte mask) between instruction fetch (requester 0) and load/store (requester 1) of the multicycle RV32E core.
- Two-way round-robin arbiter plus a transaction sequencer.
- Accepts one request, drives it downstream, waits for the response, then returns it to the owning requester.
- One transaction outstanding at a time.

Parameters:
- AW, 32, address width.
- DW, 32, data width; mask width is DW/8.
- TIMEOUT, 255, maximum WAIT cycles before an error response. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- mN_req_valid  in  1  request valid from requester N (N=0,1).
- mN_req_ready  out  1  request accepted.
- mN_req_addr  in  AW  byte address.
- mN_req_wen  in  1  1=write, 0=read.
- mN_req_wdata  in  DW  write data.
- mN_req_wmask  in  DW/8  byte enables; ignored for reads.
- mN_rsp_valid  out  1  response valid to requester N.
- mN_rsp_ready  in  1  requester N takes the response.
- mN_rsp_rdata  out  DW  read data; 0 for writes.
- mN_rsp_err  out  1  error flag.
- s_req_valid  out  1  downstream request valid.
- s_req_ready  in  1  downstream accepts the request.
- s_req_addr / s_req_wen / s_req_wdata / s_req_wmask  out  AW/1/DW/DW/8  registered request fields.
- s_rsp_valid  in  1  downstream response, single-cycle pulse; no backpressure.
- s_rsp_rdata  in  DW  downstream read data.
- s_rsp_err  in  1  downstream error.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_gnt=1, so requester 0 wins the first tie.
  - All outputs 0; request and response registers cleared.
  - Reset mid-transaction abandons it; no response is issued afterwards.
- FSM states: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - Pick a winner: the sole valid requester, or if both are valid, the one != last_gnt.
  - mW_req_ready = 1 combinationally for the winner only; loser ready = 0.
  - On the handshake, register addr/wen/wdata/wmask and owner. Next state ADDR.
- ADDR:
  - s_req_valid=1 with the registered fields, held stable until s_req_ready.
  - On s_req_ready, go to WAIT.
  - s_rsp_valid in ADDR is a protocol violation: ignored, simulation assertion fires.
- WAIT:
  - On s_rsp_valid, capture rdata (forced to 0 when wen=1) and err. Go to RESP.
- RESP:
  - mOwner_rsp_valid=1 with the captured data; the other requester's rsp_valid=0.
  - Held until rsp_ready.
  - On the handshake: last_gnt=owner, go to IDLE.
- No request is accepted while busy.
- Minimum latency:
  - Cycle T: accept.
  - T+1: s_req_valid.
  - If s_req_ready at T+1 and s_rsp_valid at T+2, owner sees rsp_valid at T+3.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1,...
- A requester may drop req_valid before it is granted; this causes no side effects.
- s_rsp_valid in IDLE or RESP is dropped.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no s_rsp_valid, go to RESP with err=1, rdata=0.
  - s_rsp_valid in the same cycle as the count reaching TIMEOUT wins; the normal response is used.
  - Downstream must never deliver a response after a timeout.
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_e enum {IDLE, ADDR, WAIT, RESP}.
  - mem_req_t struct {addr, wen, wdata, wmask}.
  - mem_rsp_t struct {rdata, err}.
  - Localparam for the default TIMEOUT.
- Sub-module mem_arb_rr: 2-way round-robin picker.
  - Inputs: valid[1:0], last_gnt.
  - Outputs: gnt one-hot, gnt_id.
  - Purely combinational.

Test Plan:
- Single read, m0 at addr 0x8000_0000; downstream ready immediately and responds next cycle with 0xDEAD_BEEF -> m0_rsp_valid at T+3, rdata 0xDEAD_BEEF, err 0, m1 idle.
- m1 write to 0x8000_0010, wdata 0x1234_5678, wmask 0b0011 -> s_req fields match exactly; m1_rsp_valid with rdata 0, err 0.
- Both requesters valid continuously for 6 transactions -> grant order 0,1,0,1,0,1; never two outstanding.
- Backpressure: s_req_ready low 4 cycles, then m0_rsp_ready low 3 cycles -> s_req fields stable throughout, rsp held stable, no new accept until the handshake completes.
- rst asserted while in WAIT -> all outputs 0 immediately; a late s_rsp_valid is dropped; the next m1 request completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT=8: no s_rsp_valid after the handshake -> rsp_valid 9 cycles after WAIT entry with err=1, rdata=0. Without the macro: still busy after 100 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, request/response
// records and the default WAIT timeout used when ARB_TIMEOUT_EN is defined.
package mem_arb_pkg;

    localparam int ARB_AW              = 32;
    localparam int ARB_DW              = 32;
    localparam int ARB_MW              = ARB_DW / 8;
    localparam int ARB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [ARB_AW-1:0] addr;
        logic              wen;
        logic [ARB_DW-1:0] wdata;
        logic [ARB_MW-1:0] wmask;
    } mem_req_t;

    typedef struct packed {
        logic [ARB_DW-1:0] rdata;
        logic              err;
    } mem_rsp_t;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin picker: a lone valid requester wins, on a tie the one
// that was not granted last time wins.
module mem_arb_rr (
    input  logic [1:0] valid_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_id_o = (valid_i == 2'b11) ? ~last_gnt_i : valid_i[1];
        gnt_o    = 2'b00;
        if (|valid_i) begin
            gnt_o[gnt_id_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between fetch (m0) and load/store (m1), one
// transaction at a time. Define ARB_TIMEOUT_EN to bound the WAIT state.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic [AW-1:0]   m0_req_addr,
    input  logic            m0_req_wen,
    input  logic [DW-1:0]   m0_req_wdata,
    input  logic [DW/8-1:0] m0_req_wmask,
    output logic            m0_rsp_valid,
    input  logic            m0_rsp_ready,
    output logic [DW-1:0]   m0_rsp_rdata,
    output logic            m0_rsp_err,
    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic [AW-1:0]   m1_req_addr,
    input  logic            m1_req_wen,
    input  logic [DW-1:0]   m1_req_wdata,
    input  logic [DW/8-1:0] m1_req_wmask,
    output logic            m1_rsp_valid,
    input  logic            m1_rsp_ready,
    output logic [DW-1:0]   m1_rsp_rdata,
    output logic            m1_rsp_err,
    output logic            s_req_valid,
    input  logic            s_req_ready,
    output logic [AW-1:0]   s_req_addr,
    output logic            s_req_wen,
    output logic [DW-1:0]   s_req_wdata,
    output logic [DW/8-1:0] s_req_wmask,
    input  logic            s_rsp_valid,
    input  logic [DW-1:0]   s_rsp_rdata,
    input  logic            s_rsp_err,
    output logic            busy
);

    arb_state_e state_q;
    mem_req_t   req_q, req_d;
    mem_rsp_t   rsp_q;
    logic       last_gnt_q, owner_q, s_req_valid_q, busy_q;
    logic [1:0] rsp_valid_q;
    logic [1:0] gnt;
    logic       gnt_id, rsp_ready_own, timed_out;

    mem_arb_rr u_rr (
        .valid_i    ({m1_req_valid, m0_req_valid}),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt),
        .gnt_id_o   (gnt_id)
    );

    // Ready is qualified by rst so every output reads 0 while reset is held.
    assign m0_req_ready  = rst && (state_q == IDLE) && gnt[0];
    assign m1_req_ready  = rst && (state_q == IDLE) && gnt[1];
    assign rsp_ready_own = owner_q ? m1_rsp_ready : m0_rsp_ready;

    always_comb begin
        req_d.addr  = gnt_id ? ARB_AW'(m1_req_addr)  : ARB_AW'(m0_req_addr);
        req_d.wen   = gnt_id ? m1_req_wen            : m0_req_wen;
        req_d.wdata = gnt_id ? ARB_DW'(m1_req_wdata) : ARB_DW'(m0_req_wdata);
        req_d.wmask = gnt_id ? ARB_MW'(m1_req_wmask) : ARB_MW'(m0_req_wmask);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q;

    // Held at zero outside WAIT, so it starts from 0 on every WAIT entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
    assign timed_out = (cnt_q == CW'(TIMEOUT));
`else
    assign timed_out = 1'b0;
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_gnt_q    <= 1'b1;
            owner_q       <= 1'b0;
            req_q         <= '0;
            rsp_q         <= '0;
            s_req_valid_q <= 1'b0;
            rsp_valid_q   <= 2'b00;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    req_q         <= req_d;
                    owner_q       <= gnt_id;
                    s_req_valid_q <= 1'b1;
                    busy_q        <= 1'b1;
                    state_q       <= ADDR;
                end
                ADDR: if (s_req_ready) begin
                    s_req_valid_q <= 1'b0;
                    state_q       <= WAIT;
                end
                WAIT: if (s_rsp_valid) begin
                    rsp_q.rdata           <= req_q.wen ? '0 : ARB_DW'(s_rsp_rdata);
                    rsp_q.err             <= s_rsp_err;
                    rsp_valid_q[owner_q]  <= 1'b1;
                    state_q               <= RESP;
                end else if (timed_out) begin
                    rsp_q.rdata           <= '0;
                    rsp_q.err             <= 1'b1;
                    rsp_valid_q[owner_q]  <= 1'b1;
                    state_q               <= RESP;
                end
                RESP: if (rsp_ready_own) begin
                    rsp_valid_q <= 2'b00;
                    last_gnt_q  <= owner_q;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_req_valid  = s_req_valid_q;
    assign s_req_addr   = req_q.addr[AW-1:0];
    assign s_req_wen    = req_q.wen;
    assign s_req_wdata  = req_q.wdata[DW-1:0];
    assign s_req_wmask  = req_q.wmask[DW/8-1:0];
    assign m0_rsp_valid = rsp_valid_q[0];
    assign m1_rsp_valid = rsp_valid_q[1];
    assign m0_rsp_rdata = rsp_valid_q[0] ? rsp_q.rdata[DW-1:0] : '0;
    assign m1_rsp_rdata = rsp_valid_q[1] ? rsp_q.rdata[DW-1:0] : '0;
    assign m0_rsp_err   = rsp_valid_q[0] && rsp_q.err;
    assign m1_rsp_err   = rsp_valid_q[1] && rsp_q.err;
    assign busy         = busy_q;

    // A response while the request is still being offered breaks the protocol.
    assert property (@(posedge clk) disable iff (!rst) !(state_q == ADDR && s_rsp_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 255;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  m;
    } req_s;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid_r = 2'b00;
    logic [31:0] addr_r  [2];
    logic [1:0]  wen_r = 2'b00;
    logic [31:0] wdata_r [2];
    logic [3:0]  wmask_r [2];
    logic [1:0]  rsp_ready_r = 2'b00;
    logic [1:0]  req_ready_w, rsp_valid_w, rsp_err_w;
    logic [31:0] rsp_rdata_w [2];
    logic        s_req_valid, s_req_wen, busy;
    logic [31:0] s_req_addr, s_req_wdata;
    logic [3:0]  s_req_wmask;
    logic        s_req_ready = 1'b0, s_rsp_valid = 1'b0, s_rsp_err = 1'b0;
    logic [31:0] s_rsp_rdata = '0;

    int n_cmp = 0, n_fail = 0;
    req_s        s_exp[$];
    logic [32:0] q0[$], q1[$];
    int          gnt_log[$];
    int  ds_ready_dly = 0, ds_rsp_dly = 0;
    bit  ds_rand = 1'b0, rsp_rand = 1'b0;
    int  rsp_rdly [2] = '{0, 0};
    bit  mdl_busy = 1'b0, mdl_last = 1'b1, mdl_owner = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst(rst_n),
        .m0_req_valid(req_valid_r[0]), .m0_req_ready(req_ready_w[0]), .m0_req_addr(addr_r[0]),
        .m0_req_wen(wen_r[0]), .m0_req_wdata(wdata_r[0]), .m0_req_wmask(wmask_r[0]),
        .m0_rsp_valid(rsp_valid_w[0]), .m0_rsp_ready(rsp_ready_r[0]), .m0_rsp_rdata(rsp_rdata_w[0]),
        .m0_rsp_err(rsp_err_w[0]),
        .m1_req_valid(req_valid_r[1]), .m1_req_ready(req_ready_w[1]), .m1_req_addr(addr_r[1]),
        .m1_req_wen(wen_r[1]), .m1_req_wdata(wdata_r[1]), .m1_req_wmask(wmask_r[1]),
        .m1_rsp_valid(rsp_valid_w[1]), .m1_rsp_ready(rsp_ready_r[1]), .m1_rsp_rdata(rsp_rdata_w[1]),
        .m1_rsp_err(rsp_err_w[1]),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err),
        .busy(busy)
    );

    function automatic logic [31:0] hash(input logic [31:0] a);
        return a ^ 32'h5EAD_BEEF;
    endfunction

    function automatic logic errf(input logic [31:0] a);
        return a[7:4] == 4'hF;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Requester driver: offers one request and records what the arbiter owes back.
    task automatic issue(input int n, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] m, input bit keep, input bit to);
        int t;
        t = 0;
        @(posedge clk); #1;
        req_valid_r[n] = 1'b1; addr_r[n] = a; wen_r[n] = w; wdata_r[n] = d; wmask_r[n] = m;
        @(negedge clk);
        while (!req_ready_w[n] && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready_w[n]) begin
            chk("req_accept_timeout", 160'd0, 160'd1);
            keep = 1'b0;
        end else begin
            s_exp.push_back('{a: a, w: w, d: d, m: m});
            if (n == 0) q0.push_back(to ? {1'b1, 32'h0} : {errf(a), w ? 32'h0 : hash(a)});
            else        q1.push_back(to ? {1'b1, 32'h0} : {errf(a), w ? 32'h0 : hash(a)});
            gnt_log.push_back(n);
        end
        @(posedge clk); #1;
        if (!keep) req_valid_r[n] = 1'b0;
    endtask

    task automatic burst(input int n, input int cnt, input bit rnd);
        for (int i = 0; i < cnt; i++) begin
            bit keep;
            keep = rnd ? ((i < cnt - 1) && ($urandom_range(0, 1) == 1)) : (i < cnt - 1);
            issue(n, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), keep, 1'b0);
            if (rnd && !keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || q0.size() != 0 || q1.size() != 0) && k < 600);
        if (k >= 600) chk("drain_timeout", 160'd1, 160'd0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        mdl_busy = 1'b0; mdl_last = 1'b1;
        q0.delete(); q1.delete(); s_exp.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, {req_ready_w, rsp_valid_w, rsp_err_w, s_req_valid, busy}, 160'd0);
        chk({nm, "_data"}, {rsp_rdata_w[0], rsp_rdata_w[1], s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}, 160'd0);
    endtask

    // Requester-side monitor: pops the expected response and holds rsp_ready off for a while.
    task automatic rsp_mon(input int n);
        logic [32:0] e, got;
        int          rd;
        bit          have;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid_w[n]) begin
                chk("rsp_exclusive", rsp_valid_w, (n == 1) ? 2'b10 : 2'b01);
                got  = {rsp_err_w[n], rsp_rdata_w[n]};
                have = 1'b1;
                if (n == 0 && q0.size() > 0)      e = q0.pop_front();
                else if (n == 1 && q1.size() > 0) e = q1.pop_front();
                else begin
                    chk("rsp_unexpected", 160'd1, 160'd0);
                    have = 1'b0;
                    e = got;
                end
                if (have) chk("rsp_data", got, e);
                rd = rsp_rand ? $urandom_range(0, 3) : rsp_rdly[n];
                for (int i = 0; i < rd; i++) begin
                    @(negedge clk);
                    chk("rsp_hold", {rsp_valid_w[n], rsp_err_w[n], rsp_rdata_w[n]}, {1'b1, e});
                end
                rsp_ready_r[n] = 1'b1;
                @(negedge clk);
                rsp_ready_r[n] = 1'b0;
            end
        end
    endtask

    initial begin
        fork
            rsp_mon(0);
            rsp_mon(1);
        join_none
    end

    // Downstream memory model: optional ready stall, then one response pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && s_req_valid) begin
                req_s e;
                int   rd, sd;
                rd = ds_rand ? $urandom_range(0, 3) : ds_ready_dly;
                sd = ds_rand ? $urandom_range(0, 3) : ds_rsp_dly;
                if (s_exp.size() == 0) begin
                    chk("s_req_unexpected", 160'd1, 160'd0);
                    e = '{a: s_req_addr, w: s_req_wen, d: s_req_wdata, m: s_req_wmask};
                end else begin
                    e = s_exp.pop_front();
                    chk("s_req_fields", {s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}, e);
                end
                for (int i = 0; i < rd; i++) begin
                    @(negedge clk);
                    chk("s_req_hold", {s_req_valid, s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}, {1'b1, e});
                end
                s_req_ready = 1'b1;
                @(negedge clk);
                s_req_ready = 1'b0;
                if (sd >= 0) begin
                    repeat (sd) @(negedge clk);
                    s_rsp_valid = 1'b1; s_rsp_rdata = hash(e.a); s_rsp_err = errf(e.a);
                    @(negedge clk);
                    s_rsp_valid = 1'b0; s_rsp_rdata = '0; s_rsp_err = 1'b0;
                end
            end
        end
    end

    // Arbitration model: who may be granted, and whether a transaction is open.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (rst_n) begin
                bit e0, e1;
                e0 = !mdl_busy && req_valid_r[0] && (!req_valid_r[1] || mdl_last);
                e1 = !mdl_busy && req_valid_r[1] && (!req_valid_r[0] || !mdl_last);
                chk("req_ready", req_ready_w, {e1, e0});
                chk("busy", busy, mdl_busy);
                if (e0 || e1) begin
                    mdl_busy = 1'b1;
                    mdl_owner = e1;
                end else if (mdl_busy && rsp_valid_w[mdl_owner] && rsp_ready_r[mdl_owner]) begin
                    mdl_busy = 1'b0;
                    mdl_last = mdl_owner;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        bit first;
        for (int i = 0; i < 2; i++) begin
            addr_r[i] = '0; wdata_r[i] = '0; wmask_r[i] = '0;
        end
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(0, 32'h8000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid_w[0] && k < 20);
        chk("min_latency", k, 3);
        chk("read_data", {rsp_err_w[0], rsp_rdata_w[0]}, {1'b0, 32'hDEAD_BEEF});
        wait_idle();

        issue(1, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'b0011, 1'b0, 1'b0);
        wait_idle();

        gnt_log.delete();
        first = !mdl_last;
        fork
            burst(0, 3, 1'b0);
            burst(1, 3, 1'b0);
        join
        wait_idle();
        chk("grant_count", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            chk("grant_order", gnt_log[i], first ^ i[0]);

        ds_ready_dly = 4; rsp_rdly[0] = 3;
        fork
            issue(0, 32'h8000_0104, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                issue(1, 32'h8000_0208, 1'b1, 32'hCAFE_F00D, 4'b1100, 1'b0, 1'b0);
            end
        join
        wait_idle();
        ds_ready_dly = 0; rsp_rdly[0] = 0;

        ds_rsp_dly = 6;
        issue(0, 32'h8000_0300, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        req_valid_r[1] = 1'b1;
        rst_n = 1'b0;
        mdl_busy = 1'b0; mdl_last = 1'b1;
        q0.delete(); q1.delete(); s_exp.delete();
        #1 chk_zero("reset_in_wait");
        repeat (2) @(negedge clk);
        req_valid_r[1] = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("late_rsp_dropped", {busy, rsp_valid_w}, 160'd0);
        ds_rsp_dly = 0;
        issue(1, 32'h8000_0420, 1'b1, 32'hA5A5_5A5A, 4'hF, 1'b0, 1'b0);
        wait_idle();

        ds_rand = 1'b1; rsp_rand = 1'b1;
        fork
            burst(0, 15, 1'b1);
            burst(1, 15, 1'b1);
        join
        wait_idle();
        ds_rand = 1'b0; rsp_rand = 1'b0;

        ds_rsp_dly = -1;
`ifdef ARB_TIMEOUT_EN
        issue(0, 32'h8000_0500, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid_w[0] && k < 50);
        chk("timeout_latency", k, 11);
        chk("timeout_rsp", {rsp_err_w[0], rsp_rdata_w[0]}, {1'b1, 32'h0});
        wait_idle();
`else
        issue(0, 32'h8000_0500, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        chk("no_timeout_busy", {busy, rsp_valid_w}, 3'b100);
        reset_dut();
`endif
        ds_rsp_dly = 0;
        chk("s_exp_left", s_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
